tea_rr_scheduler: RTL and testbench



---
 rtl/tea_pkg.sv | 40 ++++
 rtl/tea_round_core.sv | 33 +++
 rtl/tea_rr_scheduler.sv | 139 +++++++++++++
 tb/tb_tea_rr_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared types and the single-round TEA function used by the scheduler and its
// round core.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_e;

  // k0 sits in the low word, matching the {k3,k2,k1,k0} request layout.
  typedef struct packed {
    logic [31:0] k3;
    logic [31:0] k2;
    logic [31:0] k1;
    logic [31:0] k0;
  } tea_key_t;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] sum;
  } tea_block_t;

  // v1 is updated from the freshly computed v0 within the same round.
  function automatic tea_block_t tea_round(input tea_block_t cur,
                                           input tea_key_t   key,
                                           input logic [31:0] delta);
    tea_block_t nxt;
    nxt.sum = cur.sum + delta;
    nxt.v0  = cur.v0 + (((cur.v1 << 4) + key.k0) ^ (cur.v1 + nxt.sum) ^
                        ((cur.v1 >> 5) + key.k1));
    nxt.v1  = cur.v1 + (((nxt.v0 << 4) + key.k2) ^ (nxt.v0 + nxt.sum) ^
                        ((nxt.v0 >> 5) + key.k3));
    return nxt;
  endfunction

endpackage

// File: rtl/tea_round_core.sv
// Iterative TEA datapath: holds v0/v1/sum and advances one round per step.
module tea_round_core
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = TEA_DELTA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_v0,
  input  logic [31:0] load_v1,
  input  tea_key_t    key,
  output logic [31:0] v0,
  output logic [31:0] v1
);

  tea_block_t blk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q <= '0;
    end else if (load) begin
      blk_q <= '{v0: load_v0, v1: load_v1, sum: 32'd0};
    end else if (step) begin
      blk_q <= tea_round(blk_q, key, DELTA);
    end
  end

  assign v0 = blk_q.v0;
  assign v1 = blk_q.v1;

endmodule

// File: rtl/tea_rr_scheduler.sv
// Round-robin front end that time-shares one iterative TEA engine between
// NUM_REQ requesters and returns id-tagged ciphertext on one response channel.
//
// state | meaning
// IDLE  | arbitrate; req_ready asserted for the granted requester
// RUN   | one TEA round per cycle until ROUNDS are done
// DONE  | resp_valid high, waiting for resp_ready
module tea_rr_scheduler
  import tea_pkg::*;
#(
  parameter int          NUM_REQ = 2,
  parameter int          ROUNDS  = 32,
  parameter logic [31:0] DELTA   = TEA_DELTA,
  localparam int         IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_v0,
  input  logic [32*NUM_REQ-1:0]  req_v1,
  input  logic [128*NUM_REQ-1:0] req_key,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [31:0]            resp_v0,
  output logic [31:0]            resp_v1,
  output logic                   busy,
  output logic [5:0]             round_cnt
);

  if (ROUNDS < 1 || ROUNDS > 63) begin : g_bad_rounds
    $error("tea_rr_scheduler: ROUNDS must be within 1..63");
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("tea_rr_scheduler: NUM_REQ must be within 2..4");
  end

  tea_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  tea_key_t       key_q;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] rr_next;
  logic [31:0]    sel_v0, sel_v1;
  tea_key_t       sel_key;
  logic           load, step;

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_v0  = req_v0[32*int'(grant_id) +: 32];
    sel_v1  = req_v1[32*int'(grant_id) +: 32];
    sel_key = tea_key_t'(req_key[128*int'(grant_id) +: 128]);
    rr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A request can only be granted from IDLE, so any handshake implies load.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    resp_valid = 1'b0;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (!reset && grant_found) begin
          req_ready[grant_id] = 1'b1;
          load                = 1'b1;
          state_d             = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (round_cnt == 6'(ROUNDS - 1)) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      round_cnt <= 6'd0;
      id_q      <= '0;
      key_q     <= '0;
    end else if (load) begin
      rr_ptr    <= rr_next;
      round_cnt <= 6'd0;
      id_q      <= grant_id;
      key_q     <= sel_key;
    end else if (step) begin
      round_cnt <= round_cnt + 6'd1;
    end
  end

  tea_round_core #(
    .DELTA (DELTA)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .load_v0 (sel_v0),
    .load_v1 (sel_v1),
    .key     (key_q),
    .v0      (resp_v0),
    .v1      (resp_v1)
  );

  assign resp_id = id_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tea_rr_scheduler.sv
// Directed bench for tea_rr_scheduler: a ROUNDS=32 instance for the main
// scenarios plus a ROUNDS=1 instance for the single-round boundary.
module tb_tea_rr_scheduler;

  logic         clk;
  logic         reset;

  logic [1:0]   req_valid, req_ready;
  logic [63:0]  req_v0, req_v1;
  logic [255:0] req_key;
  logic         resp_valid, resp_ready;
  logic [0:0]   resp_id;
  logic [31:0]  resp_v0, resp_v1;
  logic         busy;
  logic [5:0]   round_cnt;

  logic [1:0]   req_valid_r1, req_ready_r1;
  logic [63:0]  req_v0_r1, req_v1_r1;
  logic [255:0] req_key_r1;
  logic         resp_valid_r1, resp_ready_r1;
  logic [0:0]   resp_id_r1;
  logic [31:0]  resp_v0_r1, resp_v1_r1;
  logic         busy_r1;
  logic [5:0]   round_cnt_r1;

  int checks;
  int failures;

  localparam logic [127:0] KEY_A  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [31:0]  A_V0   = 32'h12345678;
  localparam logic [31:0]  A_V1   = 32'h9ABCDEF0;
  localparam logic [31:0]  A_C0   = 32'h5CF85E83;
  localparam logic [31:0]  A_C1   = 32'hE967E1FD;
  localparam logic [31:0]  Z_C0   = 32'h41EA3A0A;
  localparam logic [31:0]  Z_C1   = 32'h94BAA940;
  localparam logic [31:0]  R1_C0  = 32'h9E3779B9;
  localparam logic [31:0]  R1_C1  = 32'hDBE8D32F;

  tea_rr_scheduler #(.NUM_REQ(2), .ROUNDS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_v0     (req_v0),
    .req_v1     (req_v1),
    .req_key    (req_key),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_v0    (resp_v0),
    .resp_v1    (resp_v1),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  tea_rr_scheduler #(.NUM_REQ(2), .ROUNDS(1)) dut_r1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid_r1),
    .req_ready  (req_ready_r1),
    .req_v0     (req_v0_r1),
    .req_v1     (req_v1_r1),
    .req_key    (req_key_r1),
    .resp_valid (resp_valid_r1),
    .resp_ready (resp_ready_r1),
    .resp_id    (resp_id_r1),
    .resp_v0    (resp_v0_r1),
    .resp_v1    (resp_v1_r1),
    .busy       (busy_r1),
    .round_cnt  (round_cnt_r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // First step is the accept edge; returns cycles to resp_valid (-1 on timeout)
  // and how many of those cycles showed a nonzero req_ready.
  task automatic wait_resp(input bit drop, output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    do begin
      step_cycle();
      cyc++;
      if (drop) req_valid = 2'b00;
      if (req_ready !== 2'b00) bad++;
    end while (resp_valid !== 1'b1 && cyc < 100);
    if (resp_valid !== 1'b1) cyc = -1;
  endtask

  task automatic load_vectors();
    req_v0  = {32'h0, A_V0};
    req_v1  = {32'h0, A_V1};
    req_key = {128'h0, KEY_A};
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    req_v0 = '0; req_v1 = '0; req_key = '0;
    req_valid_r1 = 2'b00; resp_ready_r1 = 1'b0;
    req_v0_r1 = '0; req_v1_r1 = '0; req_key_r1 = '0;
    step_cycle();
    step_cycle();
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || round_cnt !== 6'd0) begin
      failures++;
      $display("FAIL reset_state: resp_valid=%b busy=%b round_cnt=%0d, want 0/0/0",
               resp_valid, busy, round_cnt);
    end
    checks++;
    if (resp_id !== 1'b0 || resp_v0 !== 32'h0 || resp_v1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: id=%0d v0=%h v1=%h, want zeros", resp_id, resp_v0, resp_v1);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b want 00", req_ready);
    end
    req_valid = 2'b00;
    reset = 1'b0;
    step_cycle();
  endtask

  task automatic test_single_req0();
    int cyc, bad;
    load_vectors();
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL req0_ready: req_ready=%b want 01", req_ready);
    end
    wait_resp(1'b1, cyc, bad);
    checks++;
    if (cyc !== 33) begin
      failures++;
      $display("FAIL req0_latency: cycles=%0d want 33", cyc);
    end
    checks++;
    if (resp_id !== 1'b0 || resp_v0 !== A_C0 || resp_v1 !== A_C1) begin
      failures++;
      $display("FAIL req0_data: id=%0d v0=%h v1=%h want 0 %h %h", resp_id, resp_v0, resp_v1, A_C0, A_C1);
    end
    checks++;
    if (busy !== 1'b1 || round_cnt !== 6'd32) begin
      failures++;
      $display("FAIL req0_done_status: busy=%b round_cnt=%0d want 1/32", busy, round_cnt);
    end
    resp_ready = 1'b1;
    step_cycle();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL req0_release: resp_valid=%b busy=%b want 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_single_req1_zero();
    int cyc, bad;
    req_v0 = '0; req_v1 = '0; req_key = '0;
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL req1_ready: req_ready=%b want 10", req_ready);
    end
    wait_resp(1'b1, cyc, bad);
    checks++;
    if (cyc !== 33 || resp_id !== 1'b1 || resp_v0 !== Z_C0 || resp_v1 !== Z_C1) begin
      failures++;
      $display("FAIL req1_zero: cyc=%0d id=%0d v0=%h v1=%h want 33 1 %h %h",
               cyc, resp_id, resp_v0, resp_v1, Z_C0, Z_C1);
    end
    resp_ready = 1'b1;
    step_cycle();
    resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, bad;
    logic [1:0]  exp_ready;
    logic [0:0]  exp_id;
    logic [31:0] exp_c0, exp_c1;
    req_v0  = {32'h0, A_V0};
    req_v1  = {32'h0, A_V1};
    req_key = {128'h0, KEY_A};
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp_ready = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_id    = (n % 2 == 0) ? 1'b0 : 1'b1;
      exp_c0    = (n % 2 == 0) ? A_C0 : Z_C0;
      exp_c1    = (n % 2 == 0) ? A_C1 : Z_C1;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL b2b_grant[%0d]: req_ready=%b want %b", n, req_ready, exp_ready);
      end
      wait_resp(1'b0, cyc, bad);
      checks++;
      if (cyc !== 33 || bad !== 0) begin
        failures++;
        $display("FAIL b2b_timing[%0d]: cyc=%0d ready_outside_idle=%0d want 33/0", n, cyc, bad);
      end
      checks++;
      if (resp_id !== exp_id || resp_v0 !== exp_c0 || resp_v1 !== exp_c1) begin
        failures++;
        $display("FAIL b2b_data[%0d]: id=%0d v0=%h v1=%h want %0d %h %h",
                 n, resp_id, resp_v0, resp_v1, exp_id, exp_c0, exp_c1);
      end
      step_cycle();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_one_done[%0d]: resp_valid=%b busy=%b want 0/0", n, resp_valid, busy);
      end
    end
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    step_cycle();
  endtask

  task automatic test_hold_done();
    int cyc, bad;
    int held_bad;
    load_vectors();
    req_valid = 2'b01;
    wait_resp(1'b1, cyc, bad);
    checks++;
    if (cyc !== 33 || resp_v0 !== A_C0 || resp_v1 !== A_C1 || resp_id !== 1'b0) begin
      failures++;
      $display("FAIL hold_first: cyc=%0d id=%0d v0=%h v1=%h", cyc, resp_id, resp_v0, resp_v1);
    end
    req_valid = 2'b11;
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_v0 !== A_C0 ||
          resp_v1 !== A_C1 || req_ready !== 2'b00 || busy !== 1'b1)
        held_bad++;
    end
    checks++;
    if (held_bad !== 0) begin
      failures++;
      $display("FAIL hold_stable: bad_cycles=%0d want 0", held_bad);
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL hold_no_accept_in_done: req_ready=%b want 00", req_ready);
    end
    step_cycle();
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b10) begin
      failures++;
      $display("FAIL hold_release: resp_valid=%b busy=%b req_ready=%b want 0/0/10",
               resp_valid, busy, req_ready);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL withdrawn_req: req_ready=%b want 00", req_ready);
    end
    step_cycle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL withdrawn_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bad, guard;
    load_vectors();
    req_valid = 2'b01;
    step_cycle();
    req_valid = 2'b00;
    guard = 0;
    while (round_cnt !== 6'd15 && guard < 40) begin
      step_cycle();
      guard++;
    end
    checks++;
    if (round_cnt !== 6'd15 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reach: round_cnt=%0d busy=%b want 15/1", round_cnt, busy);
    end
    reset = 1'b1;
    step_cycle();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || round_cnt !== 6'd0 ||
        resp_v0 !== 32'h0 || resp_id !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b resp_valid=%b round_cnt=%0d v0=%h id=%0d",
               busy, resp_valid, round_cnt, resp_v0, resp_id);
    end
    reset = 1'b0;
    req_v0  = {32'h0, A_V0};
    req_v1  = {32'h0, A_V1};
    req_key = {128'h0, KEY_A};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL midrun_ptr_reset: req_ready=%b want 01", req_ready);
    end
    wait_resp(1'b1, cyc, bad);
    checks++;
    if (cyc !== 33 || resp_id !== 1'b0 || resp_v0 !== A_C0 || resp_v1 !== A_C1) begin
      failures++;
      $display("FAIL midrun_fresh: cyc=%0d id=%0d v0=%h v1=%h want 33 0 %h %h",
               cyc, resp_id, resp_v0, resp_v1, A_C0, A_C1);
    end
    resp_ready = 1'b1;
    step_cycle();
    resp_ready = 1'b0;
  endtask

  task automatic test_one_round();
    int cyc;
    req_v0_r1 = '0; req_v1_r1 = '0; req_key_r1 = '0;
    req_valid_r1 = 2'b10;
    #1;
    checks++;
    if (req_ready_r1 !== 2'b10) begin
      failures++;
      $display("FAIL r1_ready: req_ready=%b want 10", req_ready_r1);
    end
    cyc = 0;
    do begin
      step_cycle();
      cyc++;
      req_valid_r1 = 2'b00;
    end while (resp_valid_r1 !== 1'b1 && cyc < 20);
    checks++;
    if (resp_valid_r1 !== 1'b1 || cyc !== 2 || round_cnt_r1 !== 6'd1) begin
      failures++;
      $display("FAIL r1_latency: valid=%b cyc=%0d round_cnt=%0d want 1/2/1",
               resp_valid_r1, cyc, round_cnt_r1);
    end
    checks++;
    if (resp_id_r1 !== 1'b1 || resp_v0_r1 !== R1_C0 || resp_v1_r1 !== R1_C1) begin
      failures++;
      $display("FAIL r1_data: id=%0d v0=%h v1=%h want 1 %h %h",
               resp_id_r1, resp_v0_r1, resp_v1_r1, R1_C0, R1_C1);
    end
    resp_ready_r1 = 1'b1;
    step_cycle();
    resp_ready_r1 = 1'b0;
    checks++;
    if (resp_valid_r1 !== 1'b0 || busy_r1 !== 1'b0) begin
      failures++;
      $display("FAIL r1_release: valid=%b busy=%b want 0/0", resp_valid_r1, busy_r1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_req0();
    test_single_req1_zero();
    test_back_to_back();
    test_hold_done();
    test_reset_mid_run();
    test_one_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
